// File: rtl/seg7_pkg.sv
// Shared types and constants for the seven-segment result display.
package seg7_pkg;

  // Display pages; encoding 3 is never entered and is steered back to LO.
  typedef enum logic [1:0] {
    PAGE_LO    = 2'd0,
    PAGE_HI    = 2'd1,
    PAGE_FLAGS = 2'd2,
    PAGE_BAD   = 2'd3
  } page_e;

  // Active-low segment patterns, bit order {g,f,e,d,c,b,a}.
  localparam logic [6:0] SEG_DASH  = 7'b0111111;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  localparam logic [6:0] HEX_SEG [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
  };

  // Select the 16-bit word shown on a given page.
  function automatic logic [15:0] page_word(input page_e p,
                                            input logic [31:0] r,
                                            input logic [4:0] f);
    logic [15:0] w;
    case (p)
      PAGE_LO:    w = r[15:0];
      PAGE_HI:    w = r[31:16];
      PAGE_FLAGS: w = {11'b0, f};
      default:    w = 16'h0000;
    endcase
    return w;
  endfunction

endpackage

// File: rtl/seg7_result_display_if.sv
// Capture handshake between the fp_adder top and the display stage.
interface seg7_result_display_if;
  logic        valid_in;
  logic        ready_out;
  logic [31:0] result_in;
  logic [4:0]  flags_in;

  modport master (output valid_in, output result_in, output flags_in, input ready_out);
  modport slave  (input valid_in, input result_in, input flags_in, output ready_out);
endinterface

// File: rtl/seg7_result_display_hex_to_seg7.sv
// Combinational 4-bit hex digit to active-low seven-segment decoder.
module hex_to_seg7
  import seg7_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] seg
);

  // Table lookup of the segment pattern for one hex digit.
  always_comb begin
    seg = HEX_SEG[nibble];
  end

endmodule

// File: rtl/seg7_result_display.sv
// Captures an fp_adder {result, flags} pair and scans it onto the
// 4-digit active-low seven-segment display, one 16-bit page at a time.
module seg7_result_display
  import seg7_pkg::*;
#(
  parameter int REFRESH_DIV   = 100000,
  parameter int AUTO_PAGE_DIV = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  seg7_result_display_if.slave  cap_if,
  input  logic                  hold,
  input  logic                  page_next,
  output logic [6:0]            seg,
  output logic                  dp,
  output logic [3:0]            an,
  output logic [1:0]            page,
  output logic                  have_result
);

  localparam int RW = $clog2(REFRESH_DIV);
  localparam int AW = (AUTO_PAGE_DIV > 1) ? $clog2(AUTO_PAGE_DIV) : 1;
  localparam logic [RW-1:0] REFRESH_LAST = RW'(REFRESH_DIV - 1);
  localparam logic [AW-1:0] AUTO_LAST    = AW'((AUTO_PAGE_DIV > 0) ? AUTO_PAGE_DIV - 1 : 0);
  localparam bit            AUTO_EN      = (AUTO_PAGE_DIV > 0);

  // Captured data
  logic [31:0] result_q, result_d;
  logic [4:0]  flags_q, flags_d;
  logic        have_result_q, have_result_d;

  // Page FSM
  page_e       page_q, page_d;
  logic [1:0]  page_bits;

  // Scan and auto-page timers
  logic [RW-1:0] refresh_q, refresh_d;
  logic [1:0]    digit_q, digit_d;
  logic [AW-1:0] auto_q, auto_d;

  // Registered display outputs
  logic [6:0] seg_q, seg_d;
  logic [3:0] an_q, an_d;
  logic       dp_q, dp_d;

  logic        capture;
  logic        refresh_wrap;
  logic        auto_wrap;
  logic        advance;
  logic [15:0] word;
  logic [3:0]  nibbles [4];
  logic [3:0]  nibble;
  logic [3:0]  an_dec;
  logic [6:0]  hex_seg;

  // Captures are refused for as long as hold is asserted; nothing is queued.
  assign cap_if.ready_out = ~hold;
  assign capture          = cap_if.valid_in & ~hold;
  assign refresh_wrap     = (refresh_q == REFRESH_LAST);
  assign auto_wrap        = AUTO_EN && (auto_q == AUTO_LAST);
  assign advance          = page_next | auto_wrap;

  // Capture register next state
  always_comb begin
    result_d      = result_q;
    flags_d       = flags_q;
    have_result_d = have_result_q;
    if (capture) begin
      result_d      = cap_if.result_in;
      flags_d       = cap_if.flags_in;
      have_result_d = 1'b1;
    end
  end

  // Refresh counter and digit index; the digit only moves when the counter wraps
  always_comb begin
    refresh_d = refresh_wrap ? '0 : refresh_q + 1'b1;
    digit_d   = refresh_wrap ? digit_q + 2'd1 : digit_q;
  end

  // Auto-page counter restarts on capture, manual advance or its own wrap
  always_comb begin
    auto_d = '0;
    if (AUTO_EN && !capture && !page_next && !auto_wrap) begin
      auto_d = auto_q + 1'b1;
    end
  end

  // Page FSM state register
  always_ff @(posedge clk) begin
    if (rst) begin
      page_q <= PAGE_LO;
    end else begin
      page_q <= page_d;
    end
  end

  // Page FSM next state: a capture always lands on LO, beating any advance
  always_comb begin
    page_d = page_q;
    if (capture) begin
      page_d = PAGE_LO;
    end else begin
      case (page_q)
        PAGE_LO:    if (advance) page_d = PAGE_HI;
        PAGE_HI:    if (advance) page_d = PAGE_FLAGS;
        PAGE_FLAGS: if (advance) page_d = PAGE_LO;
        default:    page_d = PAGE_LO;
      endcase
    end
  end

  // Page FSM output: current page as a plain 2-bit code
  always_comb begin
    page_bits = page_q;
  end

  // Datapath and timer registers
  always_ff @(posedge clk) begin
    if (rst) begin
      result_q      <= '0;
      flags_q       <= '0;
      have_result_q <= 1'b0;
      refresh_q     <= '0;
      digit_q       <= '0;
      auto_q        <= '0;
    end else begin
      result_q      <= result_d;
      flags_q       <= flags_d;
      have_result_q <= have_result_d;
      refresh_q     <= refresh_d;
      digit_q       <= digit_d;
      auto_q        <= auto_d;
    end
  end

  // Split the page word into digits and decode the anode one-hot (active-low)
  always_comb begin
    word = page_word(page_q, result_q, flags_q);
  end

  for (genvar gi = 0; gi < 4; gi++) begin : g_digit
    assign nibbles[gi] = word[4*gi +: 4];
    assign an_dec[gi]  = (digit_q != 2'(gi));
  end

  // Pick the nibble of the digit currently being scanned
  always_comb begin
    nibble = nibbles[digit_q];
  end

  hex_to_seg7 u_hex (
    .nibble (nibble),
    .seg    (hex_seg)
  );

  // Next display pattern; dashes until the first capture, dp marks the page
  always_comb begin
    seg_d = have_result_q ? hex_seg : SEG_DASH;
    an_d  = an_dec;
    dp_d  = (digit_q == page_bits) ? 1'b0 : 1'b1;
  end

  // Output registers, blanked during reset
  always_ff @(posedge clk) begin
    if (rst) begin
      seg_q <= SEG_BLANK;
      an_q  <= 4'b1111;
      dp_q  <= 1'b1;
    end else begin
      seg_q <= seg_d;
      an_q  <= an_d;
      dp_q  <= dp_d;
    end
  end

  assign seg         = seg_q;
  assign an          = an_q;
  assign dp          = dp_q;
  assign page        = page_bits;
  assign have_result = have_result_q;

endmodule

// File: tb/tb_seg7_result_display.sv
// Self-checking bench: two instances (auto paging off / every 10 cycles)
// compared every cycle against a behavioural model, plus vector table
// and directed corner-case sequences.
module tb_seg7_result_display;

  localparam int RDIV = 4;
  localparam int ADIV_B = 10;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst = 1'b1;
  logic        hold = 1'b0;
  logic        page_next = 1'b0;
  logic        valid = 1'b0;
  logic [31:0] result = '0;
  logic [4:0]  flags = '0;

  seg7_result_display_if if_a ();
  seg7_result_display_if if_b ();
  assign if_a.valid_in  = valid;
  assign if_a.result_in = result;
  assign if_a.flags_in  = flags;
  assign if_b.valid_in  = valid;
  assign if_b.result_in = result;
  assign if_b.flags_in  = flags;

  logic [6:0] seg_a, seg_b;
  logic       dp_a, dp_b;
  logic [3:0] an_a, an_b;
  logic [1:0] page_a, page_b;
  logic       have_a, have_b;

  seg7_result_display #(.REFRESH_DIV(RDIV), .AUTO_PAGE_DIV(0)) dut_a (
    .clk(clk), .rst(rst), .cap_if(if_a), .hold(hold), .page_next(page_next),
    .seg(seg_a), .dp(dp_a), .an(an_a), .page(page_a), .have_result(have_a)
  );

  seg7_result_display #(.REFRESH_DIV(RDIV), .AUTO_PAGE_DIV(ADIV_B)) dut_b (
    .clk(clk), .rst(rst), .cap_if(if_b), .hold(hold), .page_next(page_next),
    .seg(seg_b), .dp(dp_b), .an(an_b), .page(page_b), .have_result(have_b)
  );

  int n_checks = 0;
  int n_fail = 0;

  // Behavioural model state, index 0 = dut_a, 1 = dut_b
  int          m_edges = 0;
  int          m_page [2] = '{0, 0};
  int          m_since [2] = '{0, 0};
  bit          m_have [2] = '{0, 0};
  logic [31:0] m_res [2] = '{32'h0, 32'h0};
  logic [4:0]  m_flg [2] = '{5'h0, 5'h0};
  int          adiv [2] = '{0, ADIV_B};

  typedef struct {
    logic [31:0] res;
    logic [4:0]  flg;
    int          nnext;
    logic [1:0]  pg;
    logic [27:0] segs;   // {digit3, digit2, digit1, digit0}
  } vec_t;
  vec_t vt [8];

  function automatic logic [6:0] hex_seg(input logic [3:0] n);
    case (n)
      4'h0: return 7'b1000000;  4'h1: return 7'b1111001;
      4'h2: return 7'b0100100;  4'h3: return 7'b0110000;
      4'h4: return 7'b0011001;  4'h5: return 7'b0010010;
      4'h6: return 7'b0000010;  4'h7: return 7'b1111000;
      4'h8: return 7'b0000000;  4'h9: return 7'b0010000;
      4'hA: return 7'b0001000;  4'hB: return 7'b0000011;
      4'hC: return 7'b1000110;  4'hD: return 7'b0100001;
      4'hE: return 7'b0000110;  default: return 7'b0001110;
    endcase
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // One clock cycle with the currently driven inputs; checks both DUTs.
  task automatic step();
    logic [6:0]  e_seg [2];
    logic        e_dp [2];
    logic [3:0]  e_an;
    logic [15:0] w;
    logic [3:0]  nib;
    int          dig;
    bit          cap;
    bit          adv;
    logic        rdy_exp;
    #1;
    rdy_exp = !hold;
    check("ready_a", if_a.ready_out, rdy_exp);
    check("ready_b", if_b.ready_out, rdy_exp);
    dig = (m_edges / RDIV) % 4;
    e_an = 4'b0001 << dig;
    e_an = ~e_an;
    for (int i = 0; i < 2; i++) begin
      if (m_page[i] == 0)      w = m_res[i][15:0];
      else if (m_page[i] == 1) w = m_res[i][31:16];
      else                     w = {11'b0, m_flg[i]};
      nib = w[dig*4 +: 4];
      e_seg[i] = m_have[i] ? hex_seg(nib) : 7'b0111111;
      e_dp[i]  = (dig == m_page[i]) ? 1'b0 : 1'b1;
      if (rst) begin
        e_seg[i] = 7'b1111111;
        e_dp[i]  = 1'b1;
      end
    end
    if (rst) e_an = 4'b1111;
    if (rst) begin
      m_edges = 0;
      for (int i = 0; i < 2; i++) begin
        m_page[i] = 0; m_since[i] = 0; m_have[i] = 0; m_res[i] = '0; m_flg[i] = '0;
      end
    end else begin
      m_edges++;
      cap = valid && !hold;
      for (int i = 0; i < 2; i++) begin
        if (cap) begin
          m_res[i] = result; m_flg[i] = flags; m_have[i] = 1; m_page[i] = 0; m_since[i] = 0;
        end else begin
          adv = page_next || (adiv[i] != 0 && m_since[i] == adiv[i] - 1);
          if (adv) m_page[i] = (m_page[i] + 1) % 3;
          if (adiv[i] != 0) m_since[i] = page_next ? 0 : (m_since[i] + 1) % adiv[i];
        end
      end
    end
    @(posedge clk);
    #1;
    check("seg_a", seg_a, e_seg[0]);
    check("seg_b", seg_b, e_seg[1]);
    check("dp_a", dp_a, e_dp[0]);
    check("dp_b", dp_b, e_dp[1]);
    check("an_a", an_a, e_an);
    check("an_b", an_b, e_an);
    check("page_a", page_a, m_page[0]);
    check("page_b", page_b, m_page[1]);
    check("have_a", have_a, m_have[0]);
    check("have_b", have_b, m_have[1]);
  endtask

  task automatic idle(input int n);
    valid = 0; page_next = 0;
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic press();
    page_next = 1; step(); page_next = 0;
  endtask

  task automatic capture(input logic [31:0] r, input logic [4:0] f);
    result = r; flags = f; valid = 1; step(); valid = 0;
  endtask

  // Run a full scan on dut_a and record the segments shown on each digit.
  task automatic collect(output logic [27:0] segs);
    logic [3:0] msk;
    segs = '1;
    for (int c = 0; c < 18; c++) begin
      step();
      for (int k = 0; k < 4; k++) begin
        msk = 4'b0001 << k;
        msk = ~msk;
        if (an_a == msk) segs[k*7 +: 7] = seg_a;
      end
    end
  endtask

  initial begin
    logic [27:0] got;
    vt[0] = '{32'h3F800000, 5'b00000, 0, 2'd0, {7'b1000000, 7'b1000000, 7'b1000000, 7'b1000000}};
    vt[1] = '{32'h3F800000, 5'b00000, 1, 2'd1, {7'b0110000, 7'b0001110, 7'b0000000, 7'b1000000}};
    vt[2] = '{32'h3F800000, 5'b10101, 2, 2'd2, {7'b1000000, 7'b1000000, 7'b1111001, 7'b0010010}};
    vt[3] = '{32'h3F800000, 5'b10101, 3, 2'd0, {7'b1000000, 7'b1000000, 7'b1000000, 7'b1000000}};
    vt[4] = '{32'hDEADBEEF, 5'b00000, 1, 2'd1, {7'b0100001, 7'b0000110, 7'b0001000, 7'b0100001}};
    vt[5] = '{32'hDEADBEEF, 5'b00000, 0, 2'd0, {7'b0000011, 7'b0000110, 7'b0000110, 7'b0001110}};
    vt[6] = '{32'h12345678, 5'b00000, 0, 2'd0, {7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000}};
    vt[7] = '{32'h9ABC0000, 5'b00000, 1, 2'd1, {7'b0010000, 7'b0001000, 7'b0000011, 7'b1000110}};

    // Reset, then dashes while scanning with no capture
    rst = 1; step(); rst = 0;
    check("rst_an", an_a, 4'b1111);
    check("rst_seg", seg_a, 7'b1111111);
    check("rst_dp", dp_a, 1'b1);
    check("rst_have", have_a, 1'b0);
    collect(got);
    check("dash_all", got, {4{7'b0111111}});

    // Table of captures and page walks
    for (int v = 0; v < 8; v++) begin
      capture(vt[v].res, vt[v].flg);
      for (int p = 0; p < vt[v].nnext; p++) press();
      collect(got);
      check($sformatf("vec%0d_page", v), page_a, vt[v].pg);
      for (int k = 0; k < 4; k++)
        check($sformatf("vec%0d_d%0d", v, k), got[k*7 +: 7], vt[v].segs[k*7 +: 7]);
    end

    // hold blocks capture; display keeps the old data
    capture(32'h11111111, 5'h0);
    hold = 1; result = 32'hDEADBEEF; valid = 1;
    #1 check("hold_ready", if_a.ready_out, 1'b0);
    step();
    valid = 0;
    press();
    collect(got);
    check("hold_keep", got, {4{7'b1111001}});
    hold = 0;
    capture(32'hDEADBEEF, 5'h0);
    press();
    collect(got);
    check("after_hold", got, {7'b0100001, 7'b0000110, 7'b0001000, 7'b0100001});

    // Capture together with page_next on page HI: capture wins
    check("pre_same_page", page_a, 2'd1);
    result = 32'hCAFE0123; flags = 5'h3; valid = 1; page_next = 1; step();
    valid = 0; page_next = 0;
    check("same_cycle_page", page_a, 2'd0);
    collect(got);
    check("same_cycle_data", got, {7'b0000000, 7'b0100100, 7'b0110000, 7'b1111000} ^ {7'b0000000, 7'b0100100, 7'b0110000, 7'b1111000} ^ {hex_seg(4'h0), hex_seg(4'h1), hex_seg(4'h2), hex_seg(4'h3)});

    // Auto paging on dut_b every 10 cycles, restarted by page_next
    capture(32'h01234567, 5'h1);
    idle(10); check("auto_p1", page_b, 2'd1);
    idle(10); check("auto_p2", page_b, 2'd2);
    idle(10); check("auto_p0", page_b, 2'd0);
    idle(4); press(); check("auto_press", page_b, 2'd1);
    idle(9); check("auto_restart_hold", page_b, 2'd1);
    idle(1); check("auto_restart_step", page_b, 2'd2);

    // Reset mid-scan
    idle(6);
    rst = 1; step(); rst = 0;
    check("midrst_an", an_a, 4'b1111);
    check("midrst_have", have_a, 1'b0);
    check("midrst_page_b", page_b, 2'd0);
    idle(2);
    check("midrst_dash", seg_a, 7'b0111111);

    // Randomized traffic against the model
    for (int c = 0; c < 800; c++) begin
      rst       = ($urandom_range(0, 99) == 0);
      valid     = ($urandom_range(0, 3) == 0);
      hold      = ($urandom_range(0, 3) == 0);
      page_next = ($urandom_range(0, 7) == 0);
      result    = $urandom;
      flags     = 5'($urandom_range(0, 31));
      step();
    end
    rst = 0; valid = 0; hold = 0; page_next = 0;
    idle(4);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/seg7_result_display.md
Name: seg7_result_display

Overview:
- Downstream display stage for the fp_adder bring-up top on the Basys 3.
- Captures a completed {result, flags} pair via a valid/ready handshake and drives the 4-digit, active-low seven-segment display, time-multiplexed in hex.
- Shows one 16-bit page at a time: result low half, result high half, or flags.
- Pages advance from a pulse input, and optionally on a timer.

Parameters:
- REFRESH_DIV, 100000: clk cycles each digit stays lit (1 kHz per digit at 100 MHz); must be >= 2.
- AUTO_PAGE_DIV, 0: clk cycles between automatic page advances; 0 disables auto paging.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- valid_in  in  1  result_in/flags_in valid
- ready_out  out  1  block accepts a capture; combinational, equals ~hold
- result_in  in  32  fp_adder result
- flags_in  in  5  fp_adder flags
- hold  in  1  freeze the displayed data; captures are refused while high
- page_next  in  1  single-cycle pulse, already debounced upstream; advances page
- seg  out  7  segments {g,f,e,d,c,b,a}, active-low
- dp  out  1  decimal point, active-low
- an  out  4  digit anodes, active-low; an[0] is the rightmost digit
- page  out  2  current page: 0=LO, 1=HI, 2=FLAGS
- have_result  out  1  at least one capture since reset

Behaviour:
- Reset, synchronous, applied at the next clk edge:
  - an=4'b1111, seg=7'b1111111, dp=1, page=0, have_result=0.
  - Capture registers, refresh counter, digit index and auto-page counter all go to 0.
  - Reset mid-scan or mid-page has the same effect.
- Capture: on a clk edge with valid_in && ready_out:
  - result_reg<=result_in, flags_reg<=flags_in, have_result<=1, page<=LO, auto-page counter<=0.
  - The new data is visible once the next digit update occurs.
- Page FSM: LO -> HI -> FLAGS -> LO on page_next, or on auto-page counter wrap (AUTO_PAGE_DIV-1 -> 0).
  - Encoding 3 is unreachable; if ever present, the next edge goes to LO.
  - page_next clears the auto-page counter.
  - Capture together with page_next or auto-wrap in the same cycle: capture wins, page=LO.
  - Paging is allowed while hold=1 and while have_result=0.
- Page word:
  - LO = result_reg[15:0]
  - HI = result_reg[31:16]
  - FLAGS = {11'b0, flags_reg}
  - Digit k shows word[4k+3:4k].
- Scan:
  - Refresh counter runs 0..REFRESH_DIV-1. On wrap, digit index increments modulo 4; 3 -> 0 wraps.
- Output register:
  - seg/an/dp are registered.
  - The outputs reflect the digit index and page word of the previous cycle (1-cycle latency).
  - an = ~(4'b0001 << digit).
- Hex map (seg, active-low):
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000
  - 4=0011001, 5=0010010, 6=0000010, 7=1111000
  - 8=0000000, 9=0010000, A=0001000, b=0000011
  - C=1000110, d=0100001, E=0000110, F=0001110
- have_result=0: every digit shows dash, seg=0111111.
- dp=0 only when digit index == page (page marker); otherwise dp=1.
- hold=1 blocks captures only. The scan continues, and valid_in is simply not acknowledged; no data is queued.

Decomposition:
- Package seg7_pkg:
  - Page encodings PAGE_LO/PAGE_HI/PAGE_FLAGS.
  - SEG_DASH and SEG_BLANK constants.
  - Hex-to-segment constant table.
- Sub-module: hex_to_seg7 (purely combinational 4-bit -> 7-bit decoder, used once on the selected nibble).

Test Plan:
Bench uses REFRESH_DIV=4, AUTO_PAGE_DIV=0 unless stated.
1. Reset with no capture: over 16+ cycles an walks 1110, 1101, 1011, 0111, 1110; seg stays 0111111; dp=0 only while an=1110; have_result=0.
2. Capture result_in=0x3F800000, flags_in=0: page=0 and all digits show 1000000. After page_next, page=1: an=0111 gives seg 0110000 ('3'), an=1011 gives 0001110 ('F'), an=1101 gives 0000000 ('8'), an=1110 gives 1000000.
3. Capture flags_in=5'b10101, then page_next ×2: page=2; digit0 = 0010010 ('5'), digit1 = 1111001 ('1'), digits 2-3 = 1000000. One more page_next gives page=0.
4. hold=1: ready_out=0; valid_in with 0xDEADBEEF leaves the display unchanged. hold=0 with valid_in: captured, and page HI shows d,E,A,d.
5. On page=1, valid_in and page_next in the same cycle: page=0, new data shown.
6. AUTO_PAGE_DIV=10 after a capture: page steps 0 -> 1 -> 2 -> 0 every 10 cycles; page_next restarts the count. Then rst mid-scan: next edge an=1111, have_result=0, dashes follow.
